// File: rtl/izh_pkg.sv
// Shared types for the Izhikevich timestep scheduler: Q16.16 fixed-point word,
// per-neuron state record and the scheduler FSM encoding.
package izh_pkg;
  localparam int N = 32;
  localparam int Q = 16;

  typedef logic signed [N-1:0] fx_t;

  localparam fx_t FX_ONE = fx_t'(1) <<< Q;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_CALC,
    S_WB,
    S_DONE
  } state_e;

  typedef struct packed {
    fx_t v;
    fx_t w;
  } nstate_t;

  function automatic fx_t fx_int(input int x);
    return fx_t'(x) <<< Q;
  endfunction
endpackage

// File: rtl/izh_state_ram.sv
// Per-neuron v/w storage: one write port, one registered read port.
// The array is never reset. Only the read register is reset.
module izh_state_ram
  import izh_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  nstate_t       wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output nstate_t       rdata
);

  nstate_t mem [DEPTH];
  nstate_t rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // The read register holds its value between reads, so the datapath operands stay stable.
  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/izh_timestep_scheduler.sv
// Sequences one Euler step over all neurons through a shared dv/dw datapath.
// Optional IZH_SPIKE_COUNT_EN adds a per-timestep spike counter output.
module izh_timestep_scheduler
  import izh_pkg::*;
#(
  parameter int NUM_NEURONS = 16,
  parameter int IDX_W       = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic             done,
  input  fx_t              a,
  input  fx_t              b,
  input  fx_t              c,
  input  fx_t              d,
  input  fx_t              v_th,
  input  logic             init_we,
  input  logic [IDX_W-1:0] init_idx,
  input  fx_t              init_v,
  input  fx_t              init_w,
  output logic [IDX_W-1:0] i_idx,
  input  fx_t              i_in,
  output fx_t              dp_v,
  output fx_t              dp_w,
  output fx_t              dp_i,
  input  fx_t              dp_dv,
  input  fx_t              dp_dw,
  output logic             spike_valid,
`ifdef IZH_SPIKE_COUNT_EN
  output logic [IDX_W:0]   spike_count,
`endif
  output logic [IDX_W-1:0] spike_idx
);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] spike_idx_q, spike_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             spike_valid_q, spike_valid_d;
  fx_t              dp_i_q, dp_i_d;
  fx_t              v_new_q, v_new_d;
  fx_t              w_new_q, w_new_d;
  logic             last, spike;

  logic             ram_we, ram_re;
  logic [IDX_W-1:0] ram_waddr;
  nstate_t          ram_wdata, ram_rdata;

  assign last  = (idx_q == IDX_W'(NUM_NEURONS - 1));
  assign spike = (v_new_q >= v_th);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    spike_idx_d   = spike_idx_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    spike_valid_d = 1'b0;
    dp_i_d        = dp_i_q;
    v_new_d       = v_new_q;
    w_new_d       = w_new_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RD;
        end
      end
      S_RD: begin
        dp_i_d  = i_in;
        state_d = S_CALC;
      end
      S_CALC: begin
        v_new_d = dp_v + dp_dv;
        w_new_d = dp_w + dp_dw;
        state_d = S_WB;
      end
      S_WB: begin
        if (spike) begin
          spike_valid_d = 1'b1;
          spike_idx_d   = idx_q;
        end
        if (last) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = S_RD;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      spike_idx_q   <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      spike_valid_q <= 1'b0;
      dp_i_q        <= '0;
      v_new_q       <= '0;
      w_new_q       <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      spike_idx_q   <= spike_idx_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      spike_valid_q <= spike_valid_d;
      dp_i_q        <= dp_i_d;
      v_new_q       <= v_new_d;
      w_new_q       <= w_new_d;
    end
  end

  // The scheduler owns the write port while busy. Host writes are dropped then.
  always_comb begin
    ram_re    = (state_q == S_RD);
    ram_we    = init_we;
    ram_waddr = init_idx;
    ram_wdata = '{v: init_v, w: init_w};
    if (busy_q) begin
      ram_we    = (state_q == S_WB);
      ram_waddr = idx_q;
      ram_wdata = spike ? '{v: c, w: w_new_q + d} : '{v: v_new_q, w: w_new_q};
    end
  end

  izh_state_ram #(
    .DEPTH (NUM_NEURONS),
    .AW    (IDX_W)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .re    (ram_re),
    .raddr (idx_q),
    .rdata (ram_rdata)
  );

`ifdef IZH_SPIKE_COUNT_EN
  logic [IDX_W:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == S_IDLE && start)  cnt_d = '0;
    else if (state_q == S_WB && spike) cnt_d = cnt_q + (IDX_W+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign spike_count = cnt_q;
`endif

  assign busy        = busy_q;
  assign done        = done_q;
  assign spike_valid = spike_valid_q;
  assign spike_idx   = spike_idx_q;
  assign i_idx       = idx_q;
  assign dp_v        = ram_rdata.v;
  assign dp_w        = ram_rdata.w;
  assign dp_i        = dp_i_q;

endmodule

// File: tb/tb_izh_timestep_scheduler.sv
// Bench for izh_timestep_scheduler: one 1-neuron and one 16-neuron instance with a stub datapath,
// checked against an array model of the Euler step (also builds with IZH_SPIKE_COUNT_EN).
module tb_izh_timestep_scheduler;
  import izh_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int a_i, b_i, c_i, d_i, vth_i, dv_k, dw_k;
  fx_t a, b, c, d, v_th;
  assign a = a_i; assign b = b_i; assign c = c_i; assign d = d_i; assign v_th = vth_i;

  // 16-neuron instance
  logic st16, iwe16, busy16, done16, sv16;
  logic [3:0] iidx16, i_idx16, sidx16;
  fx_t iv16, iw16, i_in16, dpv16, dpw16, dpi16, dpdv16, dpdw16;
  logic [4:0] cnt16;
  int i_mem[16];
  int mv[16], mw[16];
  logic [3:0] sp16[$];
  assign i_in16 = i_mem[i_idx16];
  assign dpdv16 = fx_t'(dv_k) + dpi16;
  assign dpdw16 = fx_t'(dw_k);

  // 1-neuron instance
  logic st1, iwe1, busy1, done1, sv1;
  logic [0:0] iidx1, i_idx1, sidx1;
  fx_t iv1, iw1, i_in1, dpv1, dpw1, dpi1, dpdv1, dpdw1;
  logic [1:0] cnt1;
  logic [0:0] sp1[$];
  assign i_in1 = '0;
  assign dpdv1 = fx_t'(dv_k);
  assign dpdw1 = fx_t'(dw_k);

  izh_timestep_scheduler #(.NUM_NEURONS(16)) u16 (
    .clk(clk), .rst(rst), .start(st16), .busy(busy16), .done(done16),
    .a(a), .b(b), .c(c), .d(d), .v_th(v_th),
    .init_we(iwe16), .init_idx(iidx16), .init_v(iv16), .init_w(iw16),
    .i_idx(i_idx16), .i_in(i_in16), .dp_v(dpv16), .dp_w(dpw16), .dp_i(dpi16),
    .dp_dv(dpdv16), .dp_dw(dpdw16), .spike_valid(sv16),
`ifdef IZH_SPIKE_COUNT_EN
    .spike_count(cnt16),
`endif
    .spike_idx(sidx16)
  );

  izh_timestep_scheduler #(.NUM_NEURONS(1)) u1 (
    .clk(clk), .rst(rst), .start(st1), .busy(busy1), .done(done1),
    .a(a), .b(b), .c(c), .d(d), .v_th(v_th),
    .init_we(iwe1), .init_idx(iidx1), .init_v(iv1), .init_w(iw1),
    .i_idx(i_idx1), .i_in(i_in1), .dp_v(dpv1), .dp_w(dpw1), .dp_i(dpi1),
    .dp_dv(dpdv1), .dp_dw(dpdw1), .spike_valid(sv1),
`ifdef IZH_SPIKE_COUNT_EN
    .spike_count(cnt1),
`endif
    .spike_idx(sidx1)
  );

`ifndef IZH_SPIKE_COUNT_EN
  assign cnt16 = '0;
  assign cnt1  = '0;
`endif

  always @(posedge clk) begin
    if (sv16) sp16.push_back(sidx16);
    if (sv1)  sp1.push_back(sidx1);
  end

  function automatic int rnd_fx(input int range);
    return int'($urandom_range(0, 2 * range)) - range;
  endfunction

  task automatic init16(input int idx, input int v, input int w);
    iwe16 = 1'b1; iidx16 = 4'(idx); iv16 = v; iw16 = w;
    @(posedge clk); #1;
    iwe16 = 1'b0;
    mv[idx] = v; mw[idx] = w;
  endtask

  task automatic init1(input int v, input int w);
    iwe1 = 1'b1; iidx1 = 1'b0; iv1 = v; iw1 = w;
    @(posedge clk); #1;
    iwe1 = 1'b0;
  endtask

  // One timestep on the 16-neuron core; checks stored state of every neuron as it is read,
  // busy/done timing, spike stream, and optional counter. rst_at aborts at that cycle.
  task automatic run_step16(input bit hold, input int rst_at, input bit drop_init);
    int nv[16], nw[16];
    bit spk[16];
    int nspk, limit, k;
    logic [3:0] exp_q[$];
    nspk = 0; limit = 16;
    for (int j = 0; j < 16; j++) begin
      nv[j] = mv[j] + dv_k + i_mem[j];
      nw[j] = mw[j] + dw_k;
      spk[j] = (nv[j] >= vth_i);
      if (spk[j]) begin nv[j] = c_i; nw[j] = nw[j] + d_i; nspk++; end
    end
    sp16.delete();
    st16 = 1'b1;
    for (int n = 1; n <= 49; n++) begin
      @(posedge clk); #1;
      if (!hold) st16 = 1'b0;
      iwe16 = 1'b0;
      if (drop_init && n == 10) begin
        iwe16 = 1'b1; iidx16 = 4'd2; iv16 = $urandom; iw16 = $urandom;
      end
      if (n % 3 == 2) begin
        k = (n - 2) / 3;
        n_chk++; if (dpv16 !== fx_t'(mv[k])) begin n_fail++; $display("FAIL dp_v n%0d: got %h exp %h", k, dpv16, mv[k]); end
        n_chk++; if (dpw16 !== fx_t'(mw[k])) begin n_fail++; $display("FAIL dp_w n%0d: got %h exp %h", k, dpw16, mw[k]); end
        n_chk++; if (dpi16 !== fx_t'(i_mem[k])) begin n_fail++; $display("FAIL dp_i n%0d: got %h exp %h", k, dpi16, i_mem[k]); end
      end
      if (n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; st16 = 1'b0; iwe16 = 1'b0;
        n_chk++; if ({busy16, done16} !== 2'b00) begin n_fail++; $display("FAIL abort busy/done: got %b exp 00", {busy16, done16}); end
        limit = (n - 2) / 3;
        break;
      end
      if (n < 49) begin
        n_chk++; if ({busy16, done16} !== 2'b10) begin n_fail++; $display("FAIL busy_run cyc%0d: busy/done %b exp 10", n, {busy16, done16}); end
      end else begin
        n_chk++; if ({busy16, done16} !== 2'b01) begin n_fail++; $display("FAIL done_at_49: busy/done %b exp 01", {busy16, done16}); end
      end
`ifdef IZH_SPIKE_COUNT_EN
      if (n == 1) begin
        n_chk++; if (cnt16 !== 5'd0) begin n_fail++; $display("FAIL count_clear: got %0d exp 0", cnt16); end
      end
      if (n == 49) begin
        n_chk++; if (cnt16 !== 5'(nspk)) begin n_fail++; $display("FAIL count_done: got %0d exp %0d", cnt16, nspk); end
      end
`endif
    end
    iwe16 = 1'b0;
    @(posedge clk); #1;
    n_chk++; if ({busy16, done16} !== 2'b00) begin n_fail++; $display("FAIL idle_after: busy/done %b exp 00", {busy16, done16}); end
    for (int j = 0; j < limit; j++) begin
      mv[j] = nv[j]; mw[j] = nw[j];
      if (spk[j]) exp_q.push_back(4'(j));
    end
    n_chk++; if (sp16.size() !== exp_q.size()) begin n_fail++; $display("FAIL spike_cnt16: got %0d exp %0d", sp16.size(), exp_q.size()); end
    for (int j = 0; j < exp_q.size() && j < sp16.size(); j++) begin
      n_chk++; if (sp16[j] !== exp_q[j]) begin n_fail++; $display("FAIL spike_idx16[%0d]: got %0d exp %0d", j, sp16[j], exp_q[j]); end
    end
  endtask

  // One timestep on the single-neuron core: done exactly at cycle 4.
  task automatic run1(input int ev, input int ew, input int espk);
    sp1.delete();
    st1 = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      st1 = 1'b0;
      if (n == 2) begin
        n_chk++; if (dpv1 !== fx_t'(ev)) begin n_fail++; $display("FAIL n1 dp_v: got %h exp %h", dpv1, ev); end
        n_chk++; if (dpw1 !== fx_t'(ew)) begin n_fail++; $display("FAIL n1 dp_w: got %h exp %h", dpw1, ew); end
      end
      n_chk++; if (done1 !== (n == 4)) begin n_fail++; $display("FAIL n1 done cyc%0d: got %b exp %b", n, done1, n == 4); end
    end
    @(posedge clk); #1;
    n_chk++; if (sp1.size() !== espk) begin n_fail++; $display("FAIL n1 spikes: got %0d exp %0d", sp1.size(), espk); end
    if (espk == 1 && sp1.size() == 1) begin
      n_chk++; if (sp1[0] !== 1'b0) begin n_fail++; $display("FAIL n1 spike_idx: got %0d exp 0", sp1[0]); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_chk++; if ({busy16, done16, sv16} !== 3'b000) begin n_fail++; $display("FAIL reset flags16: got %b exp 000", {busy16, done16, sv16}); end
    n_chk++; if ({sidx16, i_idx16} !== 8'h00) begin n_fail++; $display("FAIL reset idx16: got %h exp 00", {sidx16, i_idx16}); end
    n_chk++; if ({dpv16, dpw16, dpi16} !== 96'h0) begin n_fail++; $display("FAIL reset dp16: got %h exp 0", {dpv16, dpw16, dpi16}); end
    n_chk++; if ({busy1, done1, sv1, sidx1, i_idx1} !== 5'b0) begin n_fail++; $display("FAIL reset flags1: got %b exp 0", {busy1, done1, sv1, sidx1, i_idx1}); end
    n_chk++; if ({cnt16, cnt1} !== 7'b0) begin n_fail++; $display("FAIL reset count: got %h exp 0", {cnt16, cnt1}); end
    rst = 1'b0;
  endtask

  task automatic test_single;
    c_i = 32'hFFBF0000; d_i = 32'h00080000; vth_i = 32'h001E0000;
    dv_k = 32'h00010000; dw_k = 0;
    init1(32'hFFBF0000, 0);
    run1(32'hFFBF0000, 0, 0);
    run1(32'hFFC00000, 0, 0);
    dw_k = 32'h00008000;
    init1(32'h001D8000, 32'h00020000);
    run1(32'h001D8000, 32'h00020000, 1);
    run1(32'hFFBF0000, 32'h000A8000, 0);
  endtask

  task automatic test_threshold;
    c_i = 32'hFFBF0000; d_i = 32'h00080000; vth_i = 32'h001E0000;
    dv_k = 32'h00010000; dw_k = 0;
    for (int j = 0; j < 16; j++) begin
      i_mem[j] = 0;
      init16(j, (j == 3 || j == 15) ? 32'h001D8000 : 32'hFFBF0000, 0);
    end
    run_step16(1'b0, -1, 1'b0);
    n_chk++; if (!(sp16.size() == 2 && sp16[0] == 4'd3 && sp16[1] == 4'd15)) begin n_fail++; $display("FAIL two_spikes: got %0d pulses exp idx 3,15", sp16.size()); end
  endtask

  task automatic test_random;
    for (int it = 0; it < 4; it++) begin
      vth_i = rnd_fx(30 << 16); c_i = rnd_fx(70 << 16); d_i = rnd_fx(10 << 16);
      dv_k = rnd_fx(4 << 16); dw_k = rnd_fx(2 << 16);
      for (int j = 0; j < 16; j++) begin
        i_mem[j] = rnd_fx(20 << 16);
        init16(j, rnd_fx(80 << 16), rnd_fx(20 << 16));
      end
      run_step16(1'b0, -1, it[0]);
      run_step16(1'b0, -1, 1'b0);
    end
  endtask

  task automatic test_start_held;
    run_step16(1'b1, -1, 1'b0);
    n_chk++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL held_idle: busy %b exp 0", busy16); end
    run_step16(1'b0, -1, 1'b0);
  endtask

  task automatic test_back_to_back;
    iwe16 = 1'b1; iidx16 = 4'd7; iv16 = 32'h001D0000; iw16 = 32'h00030000;
    mv[7] = 32'h001D0000; mw[7] = 32'h00030000;
    run_step16(1'b0, -1, 1'b0);
    run_step16(1'b0, -1, 1'b0);
  endtask

  task automatic test_reset_abort;
    run_step16(1'b0, 17, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
      n_chk++; if (done16 !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b exp 0", done16); end
    end
    run_step16(1'b0, -1, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    st16 = 0; iwe16 = 0; iidx16 = 0; iv16 = 0; iw16 = 0;
    st1 = 0; iwe1 = 0; iidx1 = 0; iv1 = 0; iw1 = 0;
    a_i = 32'h00000147; b_i = 32'h00003333; c_i = 0; d_i = 0; vth_i = 0; dv_k = 0; dw_k = 0;
    for (int j = 0; j < 16; j++) begin i_mem[j] = 0; mv[j] = 0; mw[j] = 0; end
    test_reset;
    test_single;
    test_threshold;
    test_random;
    test_start_held;
    test_back_to_back;
    test_reset_abort;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
